seg_scan_multi: RTL and testbench



---
 rtl/seg_pkg.sv | 41 ++++
 rtl/seg_hex_font.sv | 11 +
 rtl/seg_scan_multi.sv | 130 +++++++++++++
 tb/tb_seg_scan_multi.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: bit positions, all-off/all-on masks and
// the active-high hex font used by every display block.
package seg_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   localparam logic [7:0] SEG_OFF = 8'h00;
   localparam logic [7:0] SEG_ALL = 8'hFF;

   // {g,f,e,d,c,b,a}, lit = 1
   function automatic logic [6:0] hex_font(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg_hex_font.sv
// Combinational hex-to-seven-segment decoder, active-high, no decimal point.
module seg_hex_font
   import seg_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = hex_font(hex);

endmodule

// File: rtl/seg_scan_multi.sv
// Multiplexed NUM_DIGITS hex display scanner with frame-synchronous input
// snapshot, per-digit dp/blank/blink, leading-zero suppression and PWM dimming.
module seg_scan_multi
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS     = 8,
   parameter int SCAN_DIV       = 500,
   parameter int BLINK_FRAMES   = 250,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int SEL_ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic [NUM_DIGITS-1:0]   blink_in,
   input  logic                    lz_en,
   input  logic [3:0]              brightness,
   output logic [7:0]              seg_data,
   output logic [NUM_DIGITS-1:0]   seg_sel,
   output logic                    frame_start
);

   localparam int PW   = $clog2(SCAN_DIV);
   localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int STEP = SCAN_DIV / 16;

   localparam logic [7:0]            SEG_INV = (SEG_ACTIVE_LOW != 0) ? SEG_ALL : SEG_OFF;
   localparam logic [NUM_DIGITS-1:0] SEL_INV = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

   logic [PW-1:0] pre;
   logic [IW-1:0] idx;
   logic [FW-1:0] frame_cnt;
   logic          blink_phase;
   logic          primed;

   logic [NUM_DIGITS-1:0][3:0] sh_dig;
   logic [NUM_DIGITS-1:0]      sh_dp, sh_blank, sh_blink;
   logic                       sh_lz;
   logic [3:0]                 sh_bri;

   logic                  pre_wrap, idx_last, load, lit, dark;
   logic [PW:0]           lit_lim;
   logic [NUM_DIGITS-1:0] supp;
   logic [6:0]            glyph;
   logic [7:0]            seg_nxt;
   logic [NUM_DIGITS-1:0] sel_nxt;

   assign pre_wrap = (pre == PW'(SCAN_DIV - 1));
   assign idx_last = (idx == IW'(NUM_DIGITS - 1));
   assign load     = (pre_wrap && idx_last) || !primed;

   // Lit window is the first (brightness+1)/16 of each digit slot.
   assign lit_lim = (PW+1)'((32'(sh_bri) + 32'd1) * 32'(STEP));
   assign lit     = ({1'b0, pre} < lit_lim);

   // Suppression runs from the top digit down and stops at the first
   // non-zero value or set decimal point; digit 0 always shows.
   always_comb begin
      logic run;
      run  = sh_lz;
      supp = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         run     = run && (sh_dig[i] == 4'h0) && !sh_dp[i];
         supp[i] = run;
      end
   end

   seg_hex_font u_font (
      .hex (sh_dig[idx]),
      .seg (glyph)
   );

   assign dark = sh_blank[idx] || (sh_blink[idx] && blink_phase) || supp[idx];

   always_comb begin
      seg_nxt = SEG_OFF;
      sel_nxt = '0;
      if (lit) begin
         sel_nxt[idx] = 1'b1;
         if (!dark) seg_nxt = {sh_dp[idx], glyph};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre         <= '0;
         idx         <= '0;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
         primed      <= 1'b0;
         frame_start <= 1'b0;
         sh_dig      <= '0;
         sh_dp       <= '0;
         sh_blank    <= '0;
         sh_blink    <= '0;
         sh_lz       <= 1'b0;
         sh_bri      <= '0;
         seg_sel     <= SEL_INV;
         seg_data    <= SEG_INV;
      end else begin
         pre <= pre_wrap ? '0 : pre + 1'b1;
         if (pre_wrap) idx <= idx_last ? '0 : idx + 1'b1;
         frame_start <= load;
         if (load) begin
            sh_dig   <= digits_in;
            sh_dp    <= dp_in;
            sh_blank <= blank_in;
            sh_blink <= blink_in;
            sh_lz    <= lz_en;
            sh_bri   <= brightness;
            primed   <= 1'b1;
            // The priming load after reset does not count as a frame.
            if (primed) begin
               if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                  frame_cnt   <= '0;
                  blink_phase <= ~blink_phase;
               end else begin
                  frame_cnt <= frame_cnt + 1'b1;
               end
            end
         end
         seg_sel  <= sel_nxt ^ SEL_INV;
         seg_data <= seg_nxt ^ SEG_INV;
      end
   end

endmodule

// File: tb/tb_seg_scan_multi.sv
// Scoreboarded bench for seg_scan_multi: a cycle model built from the frame
// timing rules predicts outputs; a negedge monitor compares them.
module tb_seg_scan_multi;

   localparam int N  = 4;
   localparam int S  = 16;
   localparam int BF = 2;
   localparam int FRAME = N * S;

   localparam logic [6:0] FONT [0:15] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   typedef struct {
      logic [N-1:0] sel;
      logic [7:0]   data;
      logic         fs;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [4*N-1:0] digits_in;
   logic [N-1:0]   dp_in, blank_in, blink_in;
   logic           lz_en;
   logic [3:0]     brightness;
   logic [7:0]     seg_data;
   logic [N-1:0]   seg_sel;
   logic           frame_start;

   int n_cmp = 0;
   int n_err = 0;
   exp_t q[$];

   seg_scan_multi #(
      .NUM_DIGITS(N), .SCAN_DIV(S), .BLINK_FRAMES(BF),
      .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in),
      .blank_in(blank_in), .blink_in(blink_in), .lz_en(lz_en),
      .brightness(brightness), .seg_data(seg_data), .seg_sel(seg_sel),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   // Reference model: k = edges since reset release; snapshot taken on k==0
   // and on the last cycle of every frame; blink phase from count of loads.
   int             k, loads;
   logic [4*N-1:0] s_dig;
   logic [N-1:0]   s_dp, s_blank, s_blink;
   logic           s_lz;
   logic [3:0]     s_bri;

   always @(posedge clk) begin
      exp_t e;
      int   pre, id, phase;
      bit   zrun, dk, ld;
      if (rst) begin
         e.sel = '1; e.data = 8'hFF; e.fs = 1'b0;
         k = 0; loads = 0;
         s_dig = '0; s_dp = '0; s_blank = '0; s_blink = '0; s_lz = 1'b0; s_bri = '0;
      end else begin
         pre   = k % S;
         id    = (k / S) % N;
         phase = (loads == 0) ? 0 : ((loads - 1) / BF) % 2;
         zrun  = s_lz;
         for (int j = N - 1; j >= id; j--)
            zrun = zrun && (s_dig[4*j +: 4] == 4'h0) && !s_dp[j];
         dk = s_blank[id] || (s_blink[id] && phase == 1) || (id > 0 && zrun);
         e.sel = '0; e.data = 8'h00;
         if (pre < (int'(s_bri) + 1) * (S / 16)) begin
            e.sel[id] = 1'b1;
            if (!dk) e.data = {s_dp[id], FONT[s_dig[4*id +: 4]]};
         end
         e.sel  = ~e.sel;
         e.data = ~e.data;
         ld   = (k == 0) || (k % FRAME == FRAME - 1);
         e.fs = ld;
         if (ld) begin
            s_dig = digits_in; s_dp = dp_in; s_blank = blank_in; s_blink = blink_in;
            s_lz = lz_en; s_bri = brightness;
            loads++;
         end
         k++;
      end
      q.push_back(e);
   end

   int mcyc = 0;
   always @(negedge clk) begin
      exp_t e;
      mcyc++;
      if (q.size() > 0) begin
         e = q.pop_front();
         n_cmp++;
         if (seg_sel !== e.sel) begin
            n_err++;
            $display("FAIL seg_sel cyc=%0d got=%b exp=%b", mcyc, seg_sel, e.sel);
         end
         n_cmp++;
         if (seg_data !== e.data) begin
            n_err++;
            $display("FAIL seg_data cyc=%0d got=%h exp=%h", mcyc, seg_data, e.data);
         end
         n_cmp++;
         if (frame_start !== e.fs) begin
            n_err++;
            $display("FAIL frame_start cyc=%0d got=%b exp=%b", mcyc, frame_start, e.fs);
         end
      end
   end

   task automatic run(input int c);
      repeat (c) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; digits_in = 16'h1234; dp_in = '0; blank_in = '0; blink_in = '0;
      lz_en = 1'b0; brightness = 4'd15;
      run(3);
      rst = 1'b0;
      // first load, then tear-free update mid-frame
      run(40);
      digits_in = 16'hABCD;
      run(150);
      // leading zeros, then dp on the top digit stops suppression
      digits_in = 16'h0050; lz_en = 1'b1;
      run(130);
      dp_in = 4'b1000;
      run(130);
      // blink digit 0
      dp_in = '0; lz_en = 1'b0; digits_in = 16'h8421; blink_in = 4'b0001;
      run(300);
      // dimming
      blink_in = '0; brightness = 4'd3;
      run(140);
      brightness = 4'd0;
      run(140);
      // mid-frame reset while digit 2 is being scanned
      brightness = 4'd15;
      while (k % FRAME < 2 * S + 5) run(1);
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      run(100);
      // randomized traffic with occasional resets
      for (int it = 0; it < 30; it++) begin
         digits_in  = 16'($urandom);
         dp_in      = 4'($urandom);
         blank_in   = 4'($urandom) & 4'($urandom);
         blink_in   = 4'($urandom);
         lz_en      = 1'($urandom);
         brightness = 4'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            rst = 1'b1;
            run($urandom_range(1, 2));
            rst = 1'b0;
         end
         run($urandom_range(1, 90));
      end
      run(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
